// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types and constants for the wide add/sub scheduler
package adder_sched_pkg;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic id_t;
endpackage

// File: rtl/adder.sv
// adder: 16-bit Kogge-Stone prefix adder with carry-in and carry-out
module adder (
  output logic        cout,
  output logic [15:0] sum,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);
  logic [16:0] g, p;
  always_comb begin
    g = {a & b, cin};
    p = {a ^ b, 1'b0};
    for (int l = 0; l < 5; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
  end
  assign sum  = a ^ b ^ g[15:0];
  assign cout = g[16];
endmodule

// File: rtl/adder_wide_sched.sv
// adder_wide_sched: two-port round-robin scheduler for word-serial wide add/sub
module adder_wide_sched
  import adder_sched_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [WORD_W*NWORDS-1:0]   req0_a,
  input  logic [WORD_W*NWORDS-1:0]   req0_b,
  input  logic                       req0_sub,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [WORD_W*NWORDS-1:0]   req1_a,
  input  logic [WORD_W*NWORDS-1:0]   req1_b,
  input  logic                       req1_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [WORD_W*NWORDS-1:0]   rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf
);
  localparam int W  = WORD_W * NWORDS;
  localparam int KW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  state_t          state_q, state_d;
  id_t             rr_q, rr_d, id_q, id_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WORD_W-1:0] aw, bw, sw;
  logic            cw, g0, last, sub_in;
  assign aw = a_q[WORD_W*k_q +: WORD_W];
  assign bw = b_q[WORD_W*k_q +: WORD_W];
  adder u_adder (.cout(cw), .sum(sw), .a(aw), .b(bw), .cin(carry_q));
  assign g0         = req0_valid && (rr_q == 1'b0 || !req1_valid);
  assign req0_ready = rst_n && state_q == IDLE && g0;
  assign req1_ready = rst_n && state_q == IDLE && req1_valid && !g0;
  assign sub_in     = req1_ready ? req1_sub : req0_sub;
  assign last       = k_q == KW'(NWORDS - 1);
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (req0_ready || req1_ready) begin
      id_d    = req1_ready;
      rr_d    = !req1_ready;
      a_d     = req1_ready ? req1_a : req0_a;
      b_d     = (req1_ready ? req1_b : req0_b) ^ {W{sub_in}};
      carry_d = sub_in;
      k_d     = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[WORD_W*k_q +: WORD_W] = sw;
      carry_d = cw;
      k_d     = last ? '0 : k_q + 1'b1;
      cout_d  = last ? cw : cout_q;
      ovf_d   = last ? cw ^ aw[WORD_W-1] ^ bw[WORD_W-1] ^ sw[WORD_W-1] : ovf_q;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign rsp_valid = state_q == DONE;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
endmodule

// File: doc/adder_wide_sched.md
# adder_wide_sched

Sequencer and arbiter that shares one 16-bit prefix adder (`adder`) between two requesters and performs NWORDS×16-bit add or subtract operations by running one word per cycle through that adder. Carry-out is fed back as the next word's carry-in. Sits between two client ports and a single response port, so each datapath owns only one copy of the 16-bit adder.

## Interface
- NWORDS, 4, number of 16-bit words per operand; operand width W = 16·NWORDS; legal values 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_sub  in  1  requester 0: 1 = a − b, 0 = a + b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as above, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that issued the operation.
- rsp_sum  out  W  result.
- rsp_cout  out  1  final carry-out; for subtract, 1 = no borrow.
- rsp_ovf  out  1  two's-complement signed overflow of the W-bit result.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Grant is round-robin. rr_ptr names the requester favoured when both are valid; after every accept, rr_ptr = the other requester.
  - reqN_ready = 1 combinationally, only for the granted valid requester, only in IDLE. At most one ready is high per cycle.
  - On accept, latch a, b and sub. b is latched as ~b when sub = 1. Set carry = sub, word index k = 0, and latch id. Go to RUN.
- **RUN** (NWORDS cycles)
  - The adder sees a[16k+15:16k], b′[16k+15:16k] and cin = carry.
  - On each cycle: sum word k is written, carry = cout, k = k+1.
  - On the last word:
    - rsp_cout = cout.
    - rsp_ovf = cout ^ (a15 ^ b′15 ^ sum15), taken on the top word's bits.
    - Go to DONE.
- **DONE**
  - rsp_valid = 1. rsp_* outputs are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No request is accepted in RUN or DONE.
- Arithmetic is modulo 2^W; no saturation.
- A requester that drops valid before accept is legal; nothing is latched.

## Timing
- Reset values:
  - State = IDLE, rr_ptr = 0, k = 0, carry = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0.
  - req0_ready = req1_ready = 0 while rst_n = 0.
- Accept in cycle T (valid && ready); RUN occupies T+1 .. T+NWORDS; rsp_valid rises at T+NWORDS+1.
- Minimum spacing between accepts is NWORDS+2 cycles, reached when rsp_ready is held at 1.
- Simultaneous valids:
  - Grant goes to rr_ptr.
  - The loser keeps valid and is granted at the next IDLE, provided it still requests.
- rsp_ready high while rsp_valid is low has no effect.
- Reset asserted in any state aborts the operation within that cycle:
  - No response is produced.
  - The next cycle starts in IDLE with reset values.
- The path through the adder is combinational within one RUN cycle. Only the registered word, carry and k cross cycles.

## Structure
- Package `adder_sched_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - WORD_W = 16.
  - Requester-id type (1 bit).
- Exactly one sub-module: the existing 16-bit `adder`, instantiated once with ports cout, sum, a, b, cin.
- The arbiter, FSM, word mux and result register live in `adder_wide_sched`.

## Test plan
- **Carry ripple across a word boundary:** req0, NWORDS = 4, a = 0x0000_0000_FFFF_FFFF, b = 0x1, add → rsp_sum = 0x0000_0001_0000_0000, cout = 0, ovf = 0, id = 0, rsp_valid exactly 5 cycles after accept.
- **Subtract with borrow:** req1, a = 5, b = 7, sub → rsp_sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0, ovf = 0, id = 1. Then a = 7, b = 5, sub → sum = 2, cout = 1.
- **Signed overflow:** a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, add → sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0. Also a = 0x8000_0000_0000_0000 minus 1 → sum = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1, cout = 1.
- **Round-robin arbitration:** both valid continuously from reset with rsp_ready = 1 → accepts alternate id 0, 1, 0, 1, spaced 6 cycles apart, and no cycle has both readies high.
- **Response backpressure:** rsp_ready = 0 for 5 cycles in DONE → rsp_* stable, both readies 0. Raising rsp_ready → IDLE the next cycle, and the pending request is accepted that cycle.
- **Reset mid-RUN:** rst_n = 0 for 1 cycle during word k = 2 → no rsp_valid, all outputs at reset values, rr_ptr = 0, and a fresh request afterwards completes correctly.
